// File: rtl/vector_lsu.sv
// Strided vector load/store unit: gathers or scatters up to LANES 64-bit
// elements at base_addr + i*stride against a one-cycle-latency data memory.
module vector_lsu #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned MEM_DEPTH = 24577
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic [2:0]            vlen,
    input  logic                  dump_req,
    input  logic [LANES*64-1:0]   store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LANES*64-1:0]   load_data,
    output logic [ADDR_W-1:0]     mem_dir,
    output logic                  mem_write_flag,
    output logic                  mem_file_enable,
    output logic [63:0]           mem_data_out,
    input  logic [63:0]           mem_data_in
);

    localparam int unsigned CNT_W  = $clog2(LANES + 1);
    localparam int unsigned DATA_W = LANES * 64;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d, idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic                dump_q, dump_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    // Two-deep load tag pipeline: stage 0 = element issued this cycle,
    // stage 1 = element whose read data is on mem_data_in this cycle.
    logic                v0_q, v0_d, r0_q, r0_d, v1_q, v1_d, r1_q, r1_d;
    logic [CNT_W-1:0]    t0_q, t0_d, t1_q, t1_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]   ld_q, ld_d;
    logic [ADDR_W-1:0]   dir_q, dir_d;
    logic                we_q, we_d, fe_q, fe_d;
    logic [63:0]         dout_q, dout_d;

    logic                issue, iss_store, iss_inr;
    logic [ADDR_W-1:0]   iss_addr;
    logic [CNT_W-1:0]    iss_idx, n_in;

    assign n_in = (32'(vlen) > LANES) ? CNT_W'(LANES) : CNT_W'(vlen);

    // Next-state, element issue and load capture.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        dump_d    = dump_q;
        sdata_d   = sdata_q;
        v0_d      = 1'b0;
        t0_d      = t0_q;
        r0_d      = r0_q;
        v1_d      = v0_q;
        t1_d      = t0_q;
        r1_d      = r0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ld_d      = ld_q;
        dir_d     = dir_q;
        we_d      = 1'b0;
        fe_d      = 1'b0;
        dout_d    = dout_q;
        issue     = 1'b0;
        iss_store = 1'b0;
        iss_addr  = addr_q;
        iss_idx   = idx_q;
        iss_inr   = 1'b0;

        if (v1_q && r1_q) begin
            ld_d[32'(t1_q)*64 +: 64] = mem_data_in;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d      = n_in;
                    stride_d = stride;
                    dump_d   = dump_req;
                    sdata_d  = store_data;
                    err_d    = 1'b0;
                    ld_d     = '0;
                    busy_d   = 1'b1;
                    if (n_in == '0) begin
                        state_d = DONE;
                    end else begin
                        issue     = 1'b1;
                        iss_store = is_store;
                        iss_addr  = base_addr;
                        iss_idx   = '0;
                        if (is_store) state_d = STORE;
                        else if (n_in == CNT_W'(1)) state_d = DRAIN;
                        else state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                issue = 1'b1;
                if (idx_q == n_q - CNT_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (v1_q && (t1_q == n_q - CNT_W'(1))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            STORE: begin
                if (idx_q == n_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    issue     = 1'b1;
                    iss_store = 1'b1;
                end
            end
            DONE: begin
                // Zero-length requests arrive here still busy; finish them now.
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = ~done_q;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            iss_inr = 32'(iss_addr) < MEM_DEPTH;
            dir_d   = iss_addr;
            addr_d  = iss_addr + stride_d;
            idx_d   = iss_idx + CNT_W'(1);
            if (!iss_inr) err_d = 1'b1;
            if (iss_store) begin
                dout_d = sdata_d[32'(iss_idx)*64 +: 64];
                we_d   = iss_inr;
                fe_d   = dump_d && (iss_idx == n_d - CNT_W'(1));
            end else begin
                v0_d = 1'b1;
                t0_d = iss_idx;
                r0_d = iss_inr;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            dump_q   <= 1'b0;
            sdata_q  <= '0;
            v0_q     <= 1'b0;
            t0_q     <= '0;
            r0_q     <= 1'b0;
            v1_q     <= 1'b0;
            t1_q     <= '0;
            r1_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ld_q     <= '0;
            dir_q    <= '0;
            we_q     <= 1'b0;
            fe_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            dump_q   <= dump_d;
            sdata_q  <= sdata_d;
            v0_q     <= v0_d;
            t0_q     <= t0_d;
            r0_q     <= r0_d;
            v1_q     <= v1_d;
            t1_q     <= t1_d;
            r1_q     <= r1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ld_q     <= ld_d;
            dir_q    <= dir_d;
            we_q     <= we_d;
            fe_q     <= fe_d;
            dout_q   <= dout_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign load_data       = ld_q;
    assign mem_dir         = dir_q;
    assign mem_write_flag  = we_q;
    assign mem_file_enable = fe_q;
    assign mem_data_out    = dout_q;

endmodule
